// File: rtl/nw_alignment_reader_if.sv
// Alignment column stream between the NW traceback reader and its consumer.
// Latency: none, wires only.
// Backpressure: the column is held while col_valid && !col_ready.
// Ports: col_valid/col_ready handshake; col_c1/col_c2 characters; col_gap1/col_gap2 gap flags;
//        col_last marks the (0,0) column.
interface nw_alignment_reader_if #(
    parameter int CWIDTH = 2
) ();
    logic              col_valid;
    logic              col_ready;
    logic [CWIDTH-1:0] col_c1;
    logic [CWIDTH-1:0] col_c2;
    logic              col_gap1;
    logic              col_gap2;
    logic              col_last;

    modport master (
        output col_valid, col_c1, col_c2, col_gap1, col_gap2, col_last,
        input  col_ready
    );

    modport slave (
        input  col_valid, col_c1, col_c2, col_gap1, col_gap2, col_last,
        output col_ready
    );
endinterface

// File: rtl/nw_alignment_reader.sv
// Walks the NW traceback coordinate log ({x,y} words, (LENGTH-1,LENGTH-1) down to (0,0))
// and streams alignment columns end-of-strings first.
// Latency: first column valid 5 cycles after start (3 if the first entry is (0,0)); <=3 cycles between handshakes.
// Backpressure: column outputs are frozen while col_valid && !col_ready; no memory read is issued meanwhile.
// Ports: clk/reset (async, active-high); start pulse; s1/s2 strings; raddr/rdata read port of the
//        coordinate memory (1-cycle read latency); col stream (interface, master side);
//        busy/done/error status; col_count = columns emitted this run.
module nw_alignment_reader #(
    parameter int                LENGTH      = 10,
    parameter int                CWIDTH      = 2,
    parameter int                CORD_LENGTH = 8,
    parameter int                MEM_SIZE    = 9,
    parameter int                BYTE_SIZE   = 2*CORD_LENGTH,
    parameter logic [MEM_SIZE-1:0] BASE_ADDR = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [LENGTH*CWIDTH-1:0]   s1,
    input  logic [LENGTH*CWIDTH-1:0]   s2,
    output logic [MEM_SIZE-1:0]        raddr,
    input  logic [BYTE_SIZE-1:0]       rdata,
    nw_alignment_reader_if.master      col,
    output logic                       busy,
    output logic                       done,
    output logic                       error,
    output logic [CORD_LENGTH:0]       col_count
);

    localparam int MAX_ENTRIES = 2*LENGTH - 1;

    typedef enum logic [2:0] {
        IDLE, WAIT_CUR, LOAD_CUR, WAIT_NXT, LOAD_NXT, EMIT, DONE
    } state_t;

    state_t                 state;
    logic [BYTE_SIZE-1:0]   cur;
    logic [BYTE_SIZE-1:0]   nxt;
    logic [CORD_LENGTH:0]   entry_cnt;

    // Character lookup by coordinate; constant-indexed so it maps onto a plain mux.
    function automatic logic [CWIDTH-1:0] pick(input logic [LENGTH*CWIDTH-1:0] s,
                                               input logic [CORD_LENGTH-1:0]   idx);
        logic [CWIDTH-1:0] r;
        r = '0;
        for (int k = 0; k < LENGTH; k++) begin
            if (idx == CORD_LENGTH'(k)) r = s[k*CWIDTH +: CWIDTH];
        end
        return r;
    endfunction

    logic [CORD_LENGTH-1:0] cur_x, cur_y, rd_x, rd_y, dx, dy;
    logic                   range_ok, step_diag, step_top, step_left, overrun;

    assign cur_x = cur[BYTE_SIZE-1 -: CORD_LENGTH];
    assign cur_y = cur[CORD_LENGTH-1:0];
    assign rd_x  = rdata[BYTE_SIZE-1 -: CORD_LENGTH];
    assign rd_y  = rdata[CORD_LENGTH-1:0];
    assign dx    = cur_x - rd_x;
    assign dy    = cur_y - rd_y;

    assign range_ok  = (cur_x < CORD_LENGTH'(LENGTH)) && (cur_y < CORD_LENGTH'(LENGTH)) &&
                       (rd_x  < CORD_LENGTH'(LENGTH)) && (rd_y  < CORD_LENGTH'(LENGTH));
    assign step_diag = (dx == CORD_LENGTH'(1)) && (dy == CORD_LENGTH'(1));
    assign step_top  = (dx == '0)              && (dy == CORD_LENGTH'(1));
    assign step_left = (dx == CORD_LENGTH'(1)) && (dy == '0);
    // The entry being loaded now is number entry_cnt+1; a full-length walk must have hit (0,0) by then.
    assign overrun   = ((entry_cnt + (CORD_LENGTH+1)'(1)) >= (CORD_LENGTH+1)'(MAX_ENTRIES)) &&
                       (rdata != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            raddr         <= '0;
            cur           <= '0;
            nxt           <= '0;
            entry_cnt     <= '0;
            col.col_valid <= 1'b0;
            col.col_c1    <= '0;
            col.col_c2    <= '0;
            col.col_gap1  <= 1'b0;
            col.col_gap2  <= 1'b0;
            col.col_last  <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
            col_count     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        raddr     <= BASE_ADDR;
                        error     <= 1'b0;
                        col_count <= '0;
                        entry_cnt <= '0;
                        busy      <= 1'b1;
                        state     <= WAIT_CUR;
                    end
                end

                WAIT_CUR: state <= LOAD_CUR;

                LOAD_CUR: begin
                    cur       <= rdata;
                    entry_cnt <= (CORD_LENGTH+1)'(1);
                    if (rdata == '0) begin
                        col.col_c1    <= pick(s1, '0);
                        col.col_c2    <= pick(s2, '0);
                        col.col_gap1  <= 1'b0;
                        col.col_gap2  <= 1'b0;
                        col.col_last  <= 1'b1;
                        col.col_valid <= 1'b1;
                        state         <= EMIT;
                    end else begin
                        raddr <= raddr + MEM_SIZE'(1);
                        state <= WAIT_NXT;
                    end
                end

                WAIT_NXT: state <= LOAD_NXT;

                LOAD_NXT: begin
                    nxt       <= rdata;
                    entry_cnt <= entry_cnt + (CORD_LENGTH+1)'(1);
                    if (!range_ok || overrun || !(step_diag || step_top || step_left)) begin
                        error <= 1'b1;
                        state <= DONE;
                    end else begin
                        // Left step consumes only s2, top step only s1.
                        col.col_c1    <= step_left ? '0 : pick(s1, cur_y);
                        col.col_c2    <= step_top  ? '0 : pick(s2, cur_x);
                        col.col_gap1  <= step_left;
                        col.col_gap2  <= step_top;
                        col.col_last  <= 1'b0;
                        col.col_valid <= 1'b1;
                        state         <= EMIT;
                    end
                end

                EMIT: begin
                    if (col.col_ready) begin
                        col_count <= col_count + (CORD_LENGTH+1)'(1);
                        if (col.col_last) begin
                            col.col_valid <= 1'b0;
                            state         <= DONE;
                        end else begin
                            cur <= nxt;
                            if (nxt == '0) begin
                                // (0,0) is already in hand: present it without another read.
                                col.col_c1    <= pick(s1, '0);
                                col.col_c2    <= pick(s2, '0);
                                col.col_gap1  <= 1'b0;
                                col.col_gap2  <= 1'b0;
                                col.col_last  <= 1'b1;
                                col.col_valid <= 1'b1;
                            end else begin
                                col.col_valid <= 1'b0;
                                raddr         <= raddr + MEM_SIZE'(1);
                                state         <= WAIT_NXT;
                            end
                        end
                    end
                end

                DONE: begin
                    busy  <= 1'b0;
                    done  <= !error;
                    state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nw_alignment_reader.sv
module tb_nw_alignment_reader;
    localparam int L  = 3;
    localparam int CW = 2;
    localparam int CL = 8;
    localparam int MS = 9;
    localparam int BS = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [L*CW-1:0]   s1, s2;
    logic [MS-1:0]     raddr;
    logic [BS-1:0]     rdata;
    logic              busy, done, error;
    logic [CL:0]       col_count;

    nw_alignment_reader_if #(.CWIDTH(CW)) cif ();

    nw_alignment_reader #(
        .LENGTH(L), .CWIDTH(CW), .CORD_LENGTH(CL), .MEM_SIZE(MS), .BYTE_SIZE(BS), .BASE_ADDR('0)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .s1(s1), .s2(s2),
        .raddr(raddr), .rdata(rdata), .col(cif.master),
        .busy(busy), .done(done), .error(error), .col_count(col_count)
    );

    always #5 clk = ~clk;

    // Coordinate memory with one cycle of read latency.
    logic [BS-1:0] mem [512];
    always_ff @(posedge clk) rdata <= mem[raddr];

    int total = 0;
    int bad   = 0;

    logic [6:0] got [8];
    int         ngot, ndone, first_vld;

    // Column as {last, gap1, gap2, c1, c2}.
    function automatic logic [6:0] word();
        return {cif.col_last, cif.col_gap1, cif.col_gap2, cif.col_c1, cif.col_c2};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load_mem(input logic [BS-1:0] fill);
        for (int i = 0; i < 512; i++) mem[i] = fill;
    endtask

    // Starts a run at the current negedge and follows it until busy falls.
    // toggle=1 alternates col_ready and pokes start while busy.
    task automatic run(input bit toggle);
        bit         stalled = 1'b0;
        bit         fin     = 1'b0;
        logic [6:0] held    = '0;
        ngot = 0; ndone = 0; first_vld = -1;
        cif.col_ready = !toggle;
        start = 1'b1;
        for (int cyc = 1; cyc <= 40 && !fin; cyc++) begin
            @(posedge clk);
            @(negedge clk);
            start = toggle && (cyc == 3);
            if (stalled) chk("stall_hold", {cif.col_valid, word()}, {1'b1, held});
            if (done) ndone++;
            if (cif.col_valid && first_vld < 0) first_vld = cyc;
            cif.col_ready = toggle ? ((cyc % 2) == 0) : 1'b1;
            stalled = cif.col_valid && !cif.col_ready;
            held    = word();
            if (cif.col_valid && cif.col_ready && ngot < 8) begin
                got[ngot] = word();
                ngot++;
            end
            if (!busy) fin = 1'b1;
        end
        start = 1'b0;
        chk("run_ends", busy, 0);
    endtask

    task automatic mem_case1();
        load_mem(16'h0000);
        mem[0] = 16'h0202; mem[1] = 16'h0101; mem[2] = 16'h0000;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; cif.col_ready = 1'b0;
        s1 = {2'd2, 2'd1, 2'd0};
        s2 = {2'd2, 2'd1, 2'd0};
        load_mem(16'h0000);
        #12;
        chk("rst_valid", cif.col_valid, 0);
        chk("rst_busy",  busy, 0);
        chk("rst_done",  done, 0);
        chk("rst_error", error, 0);
        chk("rst_raddr", raddr, 0);
        chk("rst_count", col_count, 0);
        @(negedge clk); reset = 1'b0;
        @(negedge clk);

        // All-diagonal walk, ready held high.
        mem_case1();
        run(1'b0);
        chk("c1_ncol",  ngot, 3);
        chk("c1_col0",  got[0], 7'b0_0_0_10_10);
        chk("c1_col1",  got[1], 7'b0_0_0_01_01);
        chk("c1_col2",  got[2], 7'b1_0_0_00_00);
        chk("c1_count", col_count, 3);
        chk("c1_done",  ndone, 1);
        chk("c1_error", error, 0);
        chk("c1_lat",   first_vld, 5);
        @(negedge clk);
        chk("c1_done_width", done, 0);
        chk("c1_count_hold", col_count, 3);

        // Top, diagonal, left, final diagonal with distinct strings.
        s1 = {2'd3, 2'd2, 2'd1};
        s2 = {2'd1, 2'd3, 2'd2};
        load_mem(16'h0000);
        mem[0] = 16'h0202; mem[1] = 16'h0201; mem[2] = 16'h0100; mem[3] = 16'h0000;
        run(1'b0);
        chk("c2_ncol",  ngot, 4);
        chk("c2_top",   got[0], 7'b0_0_1_11_00);
        chk("c2_diag",  got[1], 7'b0_0_0_10_01);
        chk("c2_left",  got[2], 7'b0_1_0_00_11);
        chk("c2_last",  got[3], 7'b1_0_0_01_10);
        chk("c2_count", col_count, 4);
        chk("c2_done",  ndone, 1);

        // Same walk as the first case under alternating backpressure.
        s1 = {2'd2, 2'd1, 2'd0};
        s2 = {2'd2, 2'd1, 2'd0};
        mem_case1();
        run(1'b1);
        chk("c3_ncol",  ngot, 3);
        chk("c3_col0",  got[0], 7'b0_0_0_10_10);
        chk("c3_col1",  got[1], 7'b0_0_0_01_01);
        chk("c3_col2",  got[2], 7'b1_0_0_00_00);
        chk("c3_count", col_count, 3);
        chk("c3_done",  ndone, 1);

        // Illegal step dx=2.
        load_mem(16'h0000);
        mem[0] = 16'h0202; mem[1] = 16'h0001;
        run(1'b0);
        chk("c4_error", error, 1);
        chk("c4_ncol",  ngot, 0);
        chk("c4_done",  ndone, 0);
        chk("c4_count", col_count, 0);

        // First entry (0,0): single final column; start also clears error.
        s1 = {2'd3, 2'd2, 2'd1};
        s2 = {2'd1, 2'd3, 2'd2};
        load_mem(16'h0000);
        run(1'b0);
        chk("c5_error", error, 0);
        chk("c5_ncol",  ngot, 1);
        chk("c5_col",   got[0], 7'b1_0_0_01_10);
        chk("c5_lat",   first_vld, 3);
        chk("c5_count", col_count, 1);
        chk("c5_done",  ndone, 1);

        // Reset while a column is waiting, then a clean re-run.
        s1 = {2'd2, 2'd1, 2'd0};
        s2 = {2'd2, 2'd1, 2'd0};
        mem_case1();
        cif.col_ready = 1'b0;
        start = 1'b1;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 20 && !cif.col_valid; i++) @(negedge clk);
        chk("c6_pre_valid", cif.col_valid, 1);
        #2 reset = 1'b1;
        #1;
        chk("c6_rst_valid", cif.col_valid, 0);
        chk("c6_rst_busy",  busy, 0);
        chk("c6_rst_raddr", raddr, 0);
        @(negedge clk); reset = 1'b0;
        @(negedge clk);
        run(1'b0);
        chk("c6_ncol",  ngot, 3);
        chk("c6_col0",  got[0], 7'b0_0_0_10_10);
        chk("c6_col2",  got[2], 7'b1_0_0_00_00);
        chk("c6_count", col_count, 3);
        chk("c6_done",  ndone, 1);

        // Log that never reaches (0,0).
        load_mem(16'h0202);
        run(1'b0);
        chk("c7_error", error, 1);
        chk("c7_ncol",  ngot, 0);
        chk("c7_done",  ndone, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
